adc_spi_receiver: RTL and testbench
===================================

// Module: adc_spi_receiver
// PURPOSE
//  Slave-side receiver for the ADC serial link: clockless-to-FPGA capture of 16-bit words on
//  adc_spi_clock/adc_spi_data (no chip select), resynchronised into the fpga_clock domain (OSCH, 133 MHz).
//  Sits inside top between the adc_spi_* pins and the DAC SPI transmitter; its data_out/data_valid feed
//  the DAC word path. Frame alignment is recovered by idle timeout; truncated frames are flagged and discarded.
// PARAMETERS
//  WORD_BITS       16   bits per frame, MSB first
//  SYNC_STAGES     2    metastability flops on adc_spi_clock and adc_spi_data (min 2)
//  TIMEOUT_CYCLES  400  fpga_clock cycles without an SPI rising edge that ends/aborts a frame (~3 us)
// PORTS
//  fpga_clock      in   1          system clock, all logic on rising edge
//  reset           in   1          synchronous, active-high
//  adc_spi_clock   in   1          async serial clock from ADC; idles low
//  adc_spi_data    in   1          async serial data; changes on SPI falling edge, sampled on rising edge
//  data_out        out  WORD_BITS  last complete word; holds until next complete word
//  data_valid      out  1          one-cycle pulse: data_out updated this cycle
//  frame_error     out  1          one-cycle pulse: partial frame (1..WORD_BITS-1 bits) aborted by timeout
//  busy            out  1          high while 1..WORD_BITS-1 bits of current frame captured
//  frame_count     out  8          count of valid words received, wraps 255->0
// BEHAVIOUR
//  - Reset (sampled on fpga_clock while reset=1): data_out=0, data_valid=0, frame_error=0, busy=0,
//    frame_count=0, bit counter=0, shift register=0, idle counter=0, sync flops=0. Reset mid-frame
//    discards partial bits; no valid/error pulse is generated for them.
//  - Sync: clock and data each pass SYNC_STAGES flops, plus one history flop on the clock path.
//    rise = clk_sync & ~clk_hist. Data sampled from data_sync in the same cycle (same depth, so
//    data settled ~50 cycles before the edge at nominal 375 ns half-period is captured cleanly).
//  - States: IDLE (bit_cnt=0) and SHIFT (bit_cnt 1..WORD_BITS-1); busy = (state==SHIFT).
//    IDLE --rise--> SHIFT: shift <= {shift[WORD_BITS-2:0], d}, bit_cnt <= 1.
//    SHIFT --rise, bit_cnt<WORD_BITS-1--> SHIFT: shift in bit, bit_cnt++.
//    SHIFT --rise, bit_cnt==WORD_BITS-1--> IDLE: data_out <= {shift[WORD_BITS-2:0], d},
//      data_valid <= 1, frame_count++, bit_cnt <= 0 (all registered: visible the cycle after rise).
//    SHIFT --idle counter reaches TIMEOUT_CYCLES--> IDLE: frame_error <= 1, bit_cnt <= 0,
//      data_out unchanged.
//  - Idle counter: cleared on every rise; otherwise increments, saturating at TIMEOUT_CYCLES.
//    Timeout in IDLE has no effect (no error pulse). Rise and timeout in same cycle: rise wins.
//  - Latency: pin rising edge of 16th bit -> data_valid high SYNC_STAGES+2 fpga_clock edges later.
//  - Back-to-back frames with no gap: bit 17 rise starts next frame from IDLE; no error.
//  - data_valid and frame_error never assert in the same cycle; each is exactly one cycle wide.
//  - Clock high/low periods shorter than 2 fpga_clock cycles are unsupported (no requirement).
// TESTING
//  - Reset 20 ns, then 16-bit frame 0x5533 MSB first at 375 ns half-period -> one data_valid pulse,
//    data_out=0x5533, frame_count=1, frame_error never asserted, busy low after frame.
//  - 15-bit frame from 0x96AA then 100 us idle -> frame_error pulse ~TIMEOUT_CYCLES after last rise,
//    no data_valid, data_out unchanged; following frame 0x1655 -> data_out=0x1655, valid once.
//  - Frames 0x5533 then 0x1655 back-to-back (no gap) -> two valid pulses, words correct, no error.
//  - Assert reset for 1 cycle after 8 bits of 0xAAAA, then send 0x00FF -> only 0x00FF reported,
//    frame_count=1, no error pulse for the aborted bits.
//  - 256 frames of incrementing value -> frame_count wraps to 0; data_out matches each sent word.
//  - Measure pin rise (bit 16) to data_valid -> exactly SYNC_STAGES+2 fpga_clock cycles (4 default).

Source files
------------

// File: rtl/adc_spi_receiver.sv
// adc_spi_receiver
//   Slave-side receiver for the ADC serial link. adc_spi_clock and adc_spi_data are
//   asynchronous to fpga_clock, so both are resynchronised before use. Frames carry
//   WORD_BITS bits, MSB first, with no chip select. A long gap with no SPI rising edge
//   re-aligns the receiver to the frame boundary. A partial frame ended by that gap is
//   reported on frame_error and its bits are discarded.
//
// Ports
//   fpga_clock    in   system clock; all logic runs on its rising edge
//   reset         in   synchronous, active-high
//   adc_spi_clock in   asynchronous serial clock; idles low
//   adc_spi_data  in   asynchronous serial data; sampled on the SPI rising edge
//   data_out      out  last complete word; held until the next complete word
//   data_valid    out  one-cycle pulse when data_out is updated
//   frame_error   out  one-cycle pulse when a partial frame is aborted by timeout
//   busy          out  high while a partial frame is being shifted in
//   frame_count   out  number of valid words received, modulo 256
module adc_spi_receiver #(
  parameter int unsigned WORD_BITS      = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 400
) (
  input  logic                 fpga_clock,
  input  logic                 reset,
  input  logic                 adc_spi_clock,
  input  logic                 adc_spi_data,
  output logic [WORD_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy,
  output logic [7:0]           frame_count
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BitW = $clog2(WORD_BITS);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);
  localparam logic [BitW-1:0] LastBit    = BitW'(WORD_BITS - 1);

  typedef enum logic {StIdle, StShift} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_hist_q;
  logic                   rise_q;
  logic                   bit_q;

  state_e                 state_q;
  logic [BitW-1:0]        bit_cnt_q;
  logic [WORD_BITS-1:0]   shift_q;
  logic [CntW-1:0]        idle_cnt_q;

  // Synchroniser chains plus a single sample stage. The sample stage registers the
  // rise strobe together with the data bit taken in the same cycle, so the two stay
  // aligned. It also sets the pin-to-valid latency at SYNC_STAGES+2 clocks.
  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_hist_q  <= 1'b0;
      rise_q      <= 1'b0;
      bit_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], adc_spi_clock};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], adc_spi_data};
      clk_hist_q  <= clk_sync_q[SYNC_STAGES-1];
      rise_q      <= clk_sync_q[SYNC_STAGES-1] & ~clk_hist_q;
      bit_q       <= data_sync_q[SYNC_STAGES-1];
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      idle_cnt_q  <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;

      if (rise_q) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != TimeoutVal) begin
        idle_cnt_q <= idle_cnt_q + CntW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (rise_q) begin
            shift_q   <= {shift_q[WORD_BITS-2:0], bit_q};
            bit_cnt_q <= BitW'(1);
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (rise_q) begin
            if (bit_cnt_q == LastBit) begin
              data_out    <= {shift_q[WORD_BITS-2:0], bit_q};
              data_valid  <= 1'b1;
              frame_count <= frame_count + 8'd1;
              bit_cnt_q   <= '0;
              state_q     <= StIdle;
            end else begin
              shift_q   <= {shift_q[WORD_BITS-2:0], bit_q};
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end else if (idle_cnt_q == TimeoutVal) begin
            // A rise in the same cycle takes priority over the timeout (branch above).
            frame_error <= 1'b1;
            bit_cnt_q   <= '0;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

  assign busy = (state_q == StShift);

endmodule

// File: tb/tb_adc_spi_receiver.sv
`timescale 1ns / 1ps
module tb_adc_spi_receiver;

  localparam int unsigned WORD_BITS      = 16;
  localparam int unsigned SYNC_STAGES    = 2;
  localparam int unsigned TIMEOUT_CYCLES = 400;

  logic                 fpga_clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 spi_clk = 1'b0;
  logic                 spi_data = 1'b0;
  logic [WORD_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_error;
  logic                 busy;
  logic [7:0]           frame_count;

  int tests = 0;
  int fails = 0;

  // Monitor state, written only by the monitor process.
  int          vcnt = 0;
  int          ecnt = 0;
  int          overlap = 0;
  logic [15:0] words [0:511];

  adc_spi_receiver #(
    .WORD_BITS     (WORD_BITS),
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .fpga_clock   (fpga_clock),
    .reset        (reset),
    .adc_spi_clock(spi_clk),
    .adc_spi_data (spi_data),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  always #3.75 fpga_clock = ~fpga_clock;

  always @(negedge fpga_clock) begin
    if (data_valid) begin
      if (vcnt < 512) words[vcnt] = data_out;
      vcnt = vcnt + 1;
    end
    if (frame_error) ecnt = ecnt + 1;
    if (data_valid && frame_error) overlap = overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Sends the top n bits of w, MSB first. The data line changes while the clock is low,
  // and each rising edge lands 1 ns after an fpga_clock edge.
  task automatic send_bits(input logic [15:0] w, input int n, input int half);
    for (int i = 15; i > 15 - n; i--) begin
      spi_data = w[i];
      #half;
      @(posedge fpga_clock); #1;
      spi_clk = 1'b1;
      #half;
      spi_clk = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (20) @(posedge fpga_clock);
    #1;
  endtask

  int n;
  bit found;

  initial begin
    #20;
    @(posedge fpga_clock); #1;
    reset = 1'b0;
    #1;
    check("reset data_out", data_out, 0);
    check("reset data_valid", data_valid, 0);
    check("reset frame_error", frame_error, 0);
    check("reset busy", busy, 0);
    check("reset frame_count", frame_count, 0);

    // Single frame.
    send_bits(16'h5533, 16, 375);
    settle();
    check("f1 valid count", vcnt, 1);
    check("f1 data_out", data_out, 16'h5533);
    check("f1 frame_count", frame_count, 1);
    check("f1 busy", busy, 0);
    check("f1 no error", ecnt, 0);

    // 15-bit frame then a long idle: timeout aborts the partial frame.
    send_bits(16'h96AA, 14, 375);
    spi_data = 1'b1;  // bit 1 of 0x96AA
    #375;
    @(posedge fpga_clock); #1;
    spi_clk = 1'b1;
    n = 0;
    found = 0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(posedge fpga_clock); #1;
      n++;
      if (n == 50) spi_clk = 1'b0;
      if (frame_error) found = 1;
    end
    check("partial error seen", found, 1);
    check("partial error timing", (n >= TIMEOUT_CYCLES && n <= TIMEOUT_CYCLES + 10), 1);
    #100000;
    check("partial error count", ecnt, 1);
    check("partial no valid", vcnt, 1);
    check("partial data_out held", data_out, 16'h5533);
    check("partial busy low", busy, 0);
    send_bits(16'h1655, 16, 375);
    settle();
    check("after partial valid", vcnt, 2);
    check("after partial word", data_out, 16'h1655);

    // Back-to-back frames with no gap.
    send_bits(16'h5533, 16, 375);
    send_bits(16'h1655, 16, 375);
    settle();
    check("b2b valid count", vcnt, 4);
    check("b2b word 0", words[2], 16'h5533);
    check("b2b word 1", words[3], 16'h1655);
    check("b2b frame_count", frame_count, 4);
    check("b2b no error", ecnt, 1);

    // Reset mid-frame discards the partial bits.
    send_bits(16'hAAAA, 8, 375);
    @(posedge fpga_clock); #1;
    reset = 1'b1;
    @(posedge fpga_clock); #1;
    reset = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset frame_count", frame_count, 0);
    #5000;
    send_bits(16'h00FF, 16, 375);
    settle();
    check("midreset valid count", vcnt, 5);
    check("midreset word", data_out, 16'h00FF);
    check("midreset frame_count 1", frame_count, 1);
    check("midreset no error", ecnt, 1);

    // Latency from the 16th pin rise to data_valid.
    send_bits(16'hA5C3, 15, 375);
    spi_data = 1'b1;  // bit 0 of 0xA5C3
    #375;
    @(posedge fpga_clock); #1;
    spi_clk = 1'b1;
    n = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge fpga_clock); #1;
      n++;
      if (data_valid) found = 1;
    end
    check("latency valid seen", found, 1);
    check("latency cycles", n, SYNC_STAGES + 2);
    check("latency word", data_out, 16'hA5C3);
    #375;
    spi_clk = 1'b0;
    settle();
    check("latency frame_count", frame_count, 2);

    // 256 incrementing frames wrap frame_count back to 0.
    @(posedge fpga_clock); #1;
    reset = 1'b1;
    @(posedge fpga_clock); #1;
    reset = 1'b0;
    check("wrap start count", frame_count, 0);
    for (int i = 0; i < 256; i++) begin
      send_bits(16'(i), 16, 30);
      repeat (8) @(posedge fpga_clock);
      #1;
      check("wrap word", data_out, 16'(i));
    end
    check("wrap frame_count", frame_count, 0);
    check("wrap valid count", vcnt, 6 + 256);
    check("final error count", ecnt, 1);
    check("valid/error overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
